param_queue_calculator: RTL and testbench

//   Parametrised queue-based calculator; successor to the fixed 8-bit queue/ALU pair.

---
 rtl/param_queue_calculator_if.sv | 30 +++
 rtl/param_queue_calculator.sv | 239 +++++++++++++++++++++++
 tb/tb_param_queue_calculator.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_queue_calculator_if.sv
// Operator/status bundle for param_queue_calculator: op request handshake plus queue status.
// The master side issues ops; the slave side (the calculator) reports queue state.
interface param_queue_calculator_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in;
  logic [2:0]       op;
  logic             apply;
  logic             ready;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             valid;
  logic [1:0]       err_code;

  modport master (
    output in, op, apply,
    input  ready, tail, head, count, empty, full, valid, err_code
  );

  modport slave (
    input  in, op, apply,
    output ready, tail, head, count, empty, full, valid, err_code
  );
endinterface

// File: rtl/param_queue_calculator.sv
// Queue-based calculator: operands from the head, results appended at the tail.
// Define DIV_EN to build the iterative restoring divider; otherwise DIV reports err_code 3.
module param_queue_calculator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  param_queue_calculator_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_DUP   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             ready_reg;
  logic             valid_reg;
  logic [1:0]       err_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;

  // Head, second entry and tail are read asynchronously so status is visible the cycle after an update.
  logic [WIDTH-1:0] head_val;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] tail_val;
  logic             is_empty;
  logic             is_full;

  assign head_val = mem[rd_ptr_reg];
  assign next_val = mem[rd_ptr_reg + PW'(1)];
  assign tail_val = mem[wr_ptr_reg - PW'(1)];
  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == CW'(DEPTH));

  // Acceptance decode: error checks and queue effect of the op currently presented.
  logic [1:0]       acc_err;
  logic             acc_exec;
  logic             acc_push;
  logic             acc_pop;
  logic             acc_clear;
  logic [WIDTH-1:0] acc_data;

  always_comb begin
    acc_err   = 2'd0;
    acc_exec  = 1'b0;
    acc_push  = 1'b0;
    acc_pop   = 1'b0;
    acc_clear = 1'b0;
    acc_data  = bus.in;
    case (bus.op)
      OP_PUSH: begin
        if (is_full) acc_err = 2'd2;
        else         acc_push = 1'b1;
      end
      OP_POP: begin
        if (is_empty) acc_err = 2'd1;
        else          acc_pop = 1'b1;
      end
      OP_DUP: begin
        acc_data = head_val;
        if (is_empty)     acc_err = 2'd1;
        else if (is_full) acc_err = 2'd2;
        else              acc_push = 1'b1;
      end
      OP_CLEAR: acc_clear = 1'b1;
      OP_DIV: begin
`ifdef DIV_EN
        if (count_reg < CW'(2))  acc_err = 2'd1;
        else if (next_val == '0) acc_err = 2'd3;
        else                     acc_exec = 1'b1;
`else
        acc_err = 2'd3;
`endif
      end
      default: begin
        if (count_reg < CW'(2)) acc_err = 2'd1;
        else                    acc_exec = 1'b1;
      end
    endcase
  end

  logic [WIDTH-1:0] alu_res;

  always_comb begin
    alu_res = a_reg + b_reg;
    case (op_reg)
      OP_SUB:  alu_res = a_reg - b_reg;
      OP_MUL:  alu_res = a_reg * b_reg;
      default: alu_res = a_reg + b_reg;
    endcase
  end

`ifdef DIV_EN
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [CNTW-1:0]  cnt_reg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    diff      = rem_shift - {1'b0, b_reg};
    if (diff[WIDTH]) begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
  end
`endif

  // Only one writer per cycle: accepted pushes happen in IDLE, results land in COMMIT.
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;

  assign mem_we    = (state_reg == COMMIT) || (state_reg == IDLE && bus.apply && acc_push);
  assign mem_wdata = (state_reg == COMMIT) ? res_reg : acc_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_reg] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b1;
      err_reg    <= 2'd0;
      op_reg     <= OP_PUSH;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
`ifdef DIV_EN
      rem_reg    <= '0;
      quo_reg    <= '0;
      cnt_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.apply) begin
            valid_reg <= (acc_err == 2'd0);
            err_reg   <= acc_err;
            if (acc_clear) begin
              rd_ptr_reg <= '0;
              wr_ptr_reg <= '0;
              count_reg  <= '0;
            end
            if (acc_push) begin
              wr_ptr_reg <= wr_ptr_reg + PW'(1);
              count_reg  <= count_reg + CW'(1);
            end
            if (acc_pop) begin
              rd_ptr_reg <= rd_ptr_reg + PW'(1);
              count_reg  <= count_reg - CW'(1);
            end
            if (acc_exec) begin
              op_reg    <= bus.op;
              a_reg     <= head_val;
              b_reg     <= next_val;
              state_reg <= EXEC;
              ready_reg <= 1'b0;
`ifdef DIV_EN
              rem_reg   <= '0;
              quo_reg   <= head_val;
              cnt_reg   <= '0;
`endif
            end
          end
        end
        EXEC: begin
`ifdef DIV_EN
          if (op_reg == OP_DIV) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + CNTW'(1);
            if (cnt_reg == CNTW'(WIDTH - 1)) begin
              res_reg   <= quo_next;
              state_reg <= COMMIT;
            end
          end else begin
            res_reg   <= alu_res;
            state_reg <= COMMIT;
          end
`else
          res_reg   <= alu_res;
          state_reg <= COMMIT;
`endif
        end
        COMMIT: begin
          // Both operands leave the head while the result is appended: net one fewer entry.
          rd_ptr_reg <= rd_ptr_reg + PW'(2);
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
          count_reg  <= count_reg - CW'(1);
          state_reg  <= IDLE;
          ready_reg  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = ready_reg;
  assign bus.head     = is_empty ? '0 : head_val;
  assign bus.tail     = is_empty ? '0 : tail_val;
  assign bus.count    = count_reg;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.valid    = valid_reg;
  assign bus.err_code = err_reg;
endmodule

// File: tb/tb_param_queue_calculator.sv
// Bench for param_queue_calculator (WIDTH=8, DEPTH=4): queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations. Follows DIV_EN like the design.
module tb_param_queue_calculator;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_queue_calculator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  param_queue_calculator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Reference model: a plain queue of values plus a busy countdown for multi-cycle ops.
  int mq[$];
  int m_busy  = 0;
  int m_valid = 1;
  int m_err   = 0;
  int m_res   = 0;

  task automatic model_accept(input int op, input int din);
    int e;
    int n;
    e = 0;
    n = mq.size();
    case (op)
      0: if (n == DEPTH) e = 2; else mq.push_back(din);
      1: if (n == 0) e = 1; else void'(mq.pop_front());
      6: if (n == 0) e = 1; else if (n == DEPTH) e = 2; else mq.push_back(mq[0]);
      7: mq.delete();
      5: begin
`ifdef DIV_EN
        if (n < 2) e = 1;
        else if (mq[1] == 0) e = 3;
        else begin
          m_res  = mq[0] / mq[1];
          m_busy = WIDTH + 1;
        end
`else
        e = 3;
`endif
      end
      default: begin
        if (n < 2) e = 1;
        else begin
          if (op == 2)      m_res = (mq[0] + mq[1]) & MASK;
          else if (op == 3) m_res = (mq[0] - mq[1]) & MASK;
          else              m_res = (mq[0] * mq[1]) & MASK;
          m_busy = 2;
        end
      end
    endcase
    m_err   = e;
    m_valid = (e == 0) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      m_busy  = 0;
      m_valid = 1;
      m_err   = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        void'(mq.pop_front());
        void'(mq.pop_front());
        mq.push_back(m_res);
      end
    end else if (bus.apply) begin
      model_accept(int'(bus.op), int'(bus.in));
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_ready", int'(bus.ready), (m_busy == 0) ? 1 : 0);
    chk("cyc_count", int'(bus.count), mq.size());
    chk("cyc_head", int'(bus.head), (mq.size() > 0) ? mq[0] : 0);
    chk("cyc_tail", int'(bus.tail), (mq.size() > 0) ? mq[mq.size()-1] : 0);
    chk("cyc_empty", int'(bus.empty), (mq.size() == 0) ? 1 : 0);
    chk("cyc_full", int'(bus.full), (mq.size() == DEPTH) ? 1 : 0);
    chk("cyc_valid", int'(bus.valid), m_valid);
    chk("cyc_err", int'(bus.err_code), m_err);
  end

  task automatic issue(input int op, input int din);
    bus.op    = 3'(op);
    bus.in    = 8'(din);
    bus.apply = 1'b1;
    @(negedge clk);
    bus.apply = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL ready_timeout at %0t: ready still %0d after %0d cycles", $time, bus.ready, n);
    end
  endtask

  initial begin
    int n;
    bus.apply = 1'b0;
    bus.op    = 3'd0;
    bus.in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_valid", int'(bus.valid), 1);
    chk("rst_err", int'(bus.err_code), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_tail", int'(bus.tail), 0);
    chk("rst_head", int'(bus.head), 0);
    rst = 1'b1;
    @(negedge clk);

    issue(0, 5); issue(0, 3); issue(2, 0);
    wait_ready(n);
    chk("add_busy", n, 2);
    chk("add_count", int'(bus.count), 1);
    chk("add_tail", int'(bus.tail), 8);
    chk("add_head", int'(bus.head), 8);
    chk("add_valid", int'(bus.valid), 1);
    $display("ADD 5+3: busy=%0d tail=%0d count=%0d", n, bus.tail, bus.count);

    issue(7, 0); issue(0, 2); issue(0, 7); issue(3, 0);
    wait_ready(n);
    chk("sub_tail", int'(bus.tail), 8'hFB);
    $display("SUB 2-7: tail=%0h", bus.tail);

    issue(7, 0); issue(0, 20); issue(0, 16); issue(4, 0);
    wait_ready(n);
    chk("mul_tail", int'(bus.tail), 8'h40);
    $display("MUL 20*16: tail=%0h", bus.tail);

    issue(7, 0);
    repeat (4) issue(0, 4);
    chk("fill_full", int'(bus.full), 1);
    issue(0, 9);
    chk("ovf_err", int'(bus.err_code), 2);
    chk("ovf_valid", int'(bus.valid), 0);
    chk("ovf_count", int'(bus.count), 4);
    issue(1, 0);
    chk("pop_valid", int'(bus.valid), 1);
    chk("pop_count", int'(bus.count), 3);
    $display("overflow then POP: count=%0d valid=%0d", bus.count, bus.valid);

    issue(7, 0); issue(2, 0);
    chk("unf_add_err", int'(bus.err_code), 1);
    chk("unf_add_ready", int'(bus.ready), 1);
    issue(0, 1); issue(1, 0); issue(1, 0);
    chk("unf_pop_err", int'(bus.err_code), 1);
    chk("unf_pop_count", int'(bus.count), 0);
    $display("underflow: err=%0d count=%0d", bus.err_code, bus.count);

    issue(0, 100); issue(0, 7); issue(5, 0);
    wait_ready(n);
`ifdef DIV_EN
    chk("div_busy", n, 9);
    chk("div_tail", int'(bus.tail), 14);
    chk("div_count", int'(bus.count), 1);
    chk("div_valid", int'(bus.valid), 1);
    issue(7, 0); issue(0, 5); issue(0, 0); issue(5, 0);
    chk("div0_err", int'(bus.err_code), 3);
    chk("div0_count", int'(bus.count), 2);
`else
    chk("nodiv_busy", n, 0);
    chk("nodiv_err", int'(bus.err_code), 3);
    chk("nodiv_valid", int'(bus.valid), 0);
    chk("nodiv_count", int'(bus.count), 2);
`endif
    $display("DIV 100/7: busy=%0d tail=%0d err=%0d", n, bus.tail, bus.err_code);

    issue(7, 0); issue(0, 1); issue(0, 2); issue(0, 3); issue(1, 0); issue(1, 0);
    issue(0, 4); issue(0, 5); issue(0, 6);
    chk("wrap_full", int'(bus.full), 1);
    chk("wrap_head", int'(bus.head), 3);
    issue(2, 0);
    wait_ready(n);
    chk("wrap_add_count", int'(bus.count), 3);
    chk("wrap_add_head", int'(bus.head), 5);
    chk("wrap_add_tail", int'(bus.tail), 7);
    issue(6, 0);
    chk("dup_tail", int'(bus.tail), 5);
    chk("dup_full", int'(bus.full), 1);
    issue(6, 0);
    chk("dup_ovf_err", int'(bus.err_code), 2);
    $display("wrap: head=%0d tail=%0d count=%0d", bus.head, bus.tail, bus.count);

    issue(7, 0); issue(0, 100); issue(0, 7);
`ifdef DIV_EN
    issue(5, 0);
    bus.op = 3'd0; bus.in = 8'd55; bus.apply = 1'b1;
    repeat (4) @(negedge clk);
`else
    issue(2, 0);
    bus.op = 3'd0; bus.in = 8'd55; bus.apply = 1'b1;
    @(negedge clk);
`endif
    chk("hold_ready", int'(bus.ready), 0);
    chk("hold_count", int'(bus.count), 2);
    chk("hold_tail", int'(bus.tail), 7);
    bus.apply = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_ready", int'(bus.ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_count", int'(bus.count), 0);
    chk("post_rst_ready", int'(bus.ready), 1);
    chk("post_rst_valid", int'(bus.valid), 1);
    $display("reset mid-op: count=%0d ready=%0d valid=%0d", bus.count, bus.ready, bus.valid);

    issue(0, 42);
    chk("after_rst_push", int'(bus.tail), 42);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
